// File: rtl/mem_stage_pkg.sv
// Shared types and lane-handling helpers for the memory access stage.
// Helpers work on a 64-bit view; XLEN=32 users keep the low half.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  function automatic logic [7:0] make_strobe(access_size_t size, logic [2:0] addr_lo);
    logic [7:0] mask;
    case (size)
      SZ_BYTE: mask = 8'h01;
      SZ_HALF: mask = 8'h03;
      SZ_WORD: mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << addr_lo;
  endfunction

  function automatic logic [63:0] replicate_store(access_size_t size, logic [63:0] data);
    case (size)
      SZ_BYTE: return {8{data[7:0]}};
      SZ_HALF: return {4{data[15:0]}};
      SZ_WORD: return {2{data[31:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [63:0] extend_load(access_size_t size, logic is_unsigned,
                                              logic [2:0] addr_lo, logic [63:0] rdata);
    logic [63:0] lane;
    lane = rdata >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: return is_unsigned ? {56'd0, lane[7:0]}  : {{56{lane[7]}}, lane[7:0]};
      SZ_HALF: return is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      SZ_WORD: return is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: return lane;
    endcase
  endfunction

  function automatic logic is_misaligned(access_size_t size, logic [2:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/load_store_aligner.sv
// Combinational lane steering: store replication, byte enables and load extension
// for one XLEN-wide bus word.
module load_store_aligner
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] strobe,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data
);

  logic [7:0]  strobe_full;
  logic [63:0] wdata_full;
  logic [63:0] load_full;

  assign strobe_full = make_strobe(access_size_t'(size), addr_lo);
  assign wdata_full  = replicate_store(access_size_t'(size), 64'(store_data));
  assign load_full   = extend_load(access_size_t'(size), is_unsigned, addr_lo, 64'(rdata));

  assign strobe    = strobe_full[XLEN/8-1:0];
  assign wdata     = wdata_full[XLEN-1:0];
  assign load_data = load_full[XLEN-1:0];

  generate
    if (XLEN < 64) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^{strobe_full[7:XLEN/8], wdata_full[63:XLEN], load_full[63:XLEN]};
    end
  endgenerate

endmodule

// File: rtl/mem_access_stage.sv
// Single-entry pipeline memory stage: valid/ready data bus, sized accesses,
// flush handling and a forwarding record of the held instruction.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [REG_ID_WIDTH-1:0] in_rd,
  input  logic                    in_reg_write,
  input  logic                    in_mem_read,
  input  logic                    in_mem_write,
  input  logic [1:0]              in_size,
  input  logic                    in_unsigned,
  input  logic [XLEN-1:0]         in_addr,
  input  logic [XLEN-1:0]         in_store_data,
  input  logic                    in_result_ready,
  input  logic [XLEN-1:0]         in_result,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [XLEN-1:0]         mem_req_wdata,
  output logic [XLEN/8-1:0]       mem_req_strobe,
  input  logic                    mem_resp_valid,
  input  logic [XLEN-1:0]         mem_resp_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [REG_ID_WIDTH-1:0] out_rd,
  output logic                    out_reg_write,
  output logic                    out_data_ready,
  output logic [XLEN-1:0]         out_data,
  output logic                    out_misaligned,
  output logic                    fwd_valid,
  output logic [REG_ID_WIDTH-1:0] fwd_rd,
  output logic                    fwd_data_ready,
  output logic [XLEN-1:0]         fwd_data
);

  localparam int LANE_BITS = $clog2(XLEN / 8);

  mem_state_t state_reg, state_next, accept_state;
  logic killed_reg, killed_next;

  logic [XLEN-1:0]         pc_reg, addr_reg, store_data_reg, data_reg;
  logic [REG_ID_WIDTH-1:0] rd_reg;
  logic [1:0]              size_reg;
  logic reg_write_reg, mem_read_reg, mem_write_reg, unsigned_reg;
  logic data_ready_reg, misaligned_reg;

  logic            accept, in_is_mem, in_misaligned;
  logic [2:0]      in_lo, held_lo;
  logic [XLEN-1:0] load_data, aligned_wdata;
  logic [XLEN/8-1:0] aligned_strobe;

  assign in_ready  = !flush && (state_reg == IDLE || (state_reg == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign in_is_mem = in_mem_read || in_mem_write;
  assign in_lo     = (XLEN == 64) ? in_addr[2:0]  : {1'b0, in_addr[1:0]};
  assign held_lo   = (XLEN == 64) ? addr_reg[2:0] : {1'b0, addr_reg[1:0]};
  // A double access has no legal alignment on a 32-bit bus.
  assign in_misaligned = in_is_mem &&
                         (is_misaligned(access_size_t'(in_size), in_lo) ||
                          (XLEN == 32 && in_size == 2'd3));
  assign accept_state  = (!in_is_mem || in_misaligned) ? DONE : REQ;

  always_comb begin
    state_next  = state_reg;
    killed_next = killed_reg;
    case (state_reg)
      IDLE: if (accept) state_next = accept_state;
      REQ: begin
        if (flush) killed_next = 1'b1;
        if (mem_req_ready) state_next = RESP;
      end
      RESP: begin
        if (flush) killed_next = 1'b1;
        if (mem_resp_valid) begin
          state_next  = (killed_reg || flush) ? IDLE : DONE;
          killed_next = 1'b0;
        end
      end
      DONE: begin
        if (flush)          state_next = IDLE;
        else if (out_ready) state_next = accept ? accept_state : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      killed_reg     <= 1'b0;
      pc_reg         <= '0;
      rd_reg         <= '0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      size_reg       <= '0;
      unsigned_reg   <= 1'b0;
      addr_reg       <= '0;
      store_data_reg <= '0;
      data_ready_reg <= 1'b0;
      data_reg       <= '0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      killed_reg <= killed_next;
      if (accept) begin
        pc_reg         <= in_pc;
        rd_reg         <= in_rd;
        reg_write_reg  <= in_reg_write && !in_misaligned;
        mem_read_reg   <= in_mem_read && !in_misaligned;
        mem_write_reg  <= in_mem_write && !in_misaligned;
        size_reg       <= in_size;
        unsigned_reg   <= in_unsigned;
        addr_reg       <= in_addr;
        store_data_reg <= in_store_data;
        misaligned_reg <= in_misaligned;
        if (!in_reg_write || in_misaligned) begin
          data_ready_reg <= 1'b1;
          data_reg       <= '0;
        end else if (in_mem_read) begin
          data_ready_reg <= 1'b0;
          data_reg       <= '0;
        end else begin
          data_ready_reg <= in_result_ready;
          data_reg       <= in_result;
        end
      end else if (state_reg == RESP && mem_resp_valid && mem_read_reg) begin
        data_ready_reg <= 1'b1;
        data_reg       <= load_data;
      end
    end
  end

  load_store_aligner #(.XLEN(XLEN)) u_aligner (
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .addr_lo     (held_lo),
    .store_data  (store_data_reg),
    .rdata       (mem_resp_rdata),
    .strobe      (aligned_strobe),
    .wdata       (aligned_wdata),
    .load_data   (load_data)
  );

  assign mem_req_valid  = (state_reg == REQ);
  assign mem_req_write  = (state_reg == REQ) && mem_write_reg;
  assign mem_req_addr   = {addr_reg[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
  assign mem_req_wdata  = aligned_wdata;
  assign mem_req_strobe = (state_reg == REQ) ? aligned_strobe : '0;

  assign out_valid      = (state_reg == DONE);
  assign out_pc         = pc_reg;
  assign out_rd         = rd_reg;
  assign out_reg_write  = reg_write_reg;
  assign out_data_ready = data_ready_reg;
  assign out_data       = data_reg;
  assign out_misaligned = misaligned_reg;

  assign fwd_valid      = (state_reg != IDLE) && reg_write_reg && !killed_reg;
  assign fwd_rd         = rd_reg;
  assign fwd_data_ready = data_ready_reg;
  assign fwd_data       = data_reg;

  logic unused_addr;
  assign unused_addr = ^addr_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench: stimulus pushes expected writeback records, a negedge monitor
// pops and compares them whenever the stage hands an instruction downstream.
module tb_mem_access_stage;

  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int RW   = 5;

  logic clock, reset, flush;
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_addr, in_store_data, in_result;
  logic [RW-1:0]   in_rd;
  logic in_reg_write, in_mem_read, in_mem_write, in_unsigned, in_result_ready;
  logic [1:0] in_size;
  logic mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [XLEN/8-1:0] mem_req_strobe;
  logic mem_resp_valid;
  logic [XLEN-1:0] mem_resp_rdata;
  logic out_valid, out_ready, out_reg_write, out_data_ready, out_misaligned;
  logic [XLEN-1:0] out_pc, out_data;
  logic [RW-1:0] out_rd;
  logic fwd_valid, fwd_data_ready;
  logic [RW-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;

  mem_access_stage #(.XLEN(XLEN), .ADDR_WIDTH(AW), .REG_ID_WIDTH(RW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_result_ready(in_result_ready), .in_result(in_result),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_strobe(mem_req_strobe),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_data_ready(out_data_ready), .out_data(out_data),
    .out_misaligned(out_misaligned),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data_ready(fwd_data_ready), .fwd_data(fwd_data)
  );

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RW-1:0]   rd;
    logic            reg_write;
    logic            data_ready;
    logic [XLEN-1:0] data;
    logic            misaligned;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_fail = 0, n_out = 0, n_pushed = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                          input logic dr, input logic [31:0] data, input logic mis);
    exp_t e;
    e.pc = pc; e.rd = rd; e.reg_write = rw; e.data_ready = dr; e.data = data; e.misaligned = mis;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Presents one instruction and returns just after the accepting edge.
  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic rr, input logic [31:0] res);
    int k;
    in_pc = pc; in_rd = rd; in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    in_size = size; in_unsigned = uns; in_addr = addr; in_store_data = sdata;
    in_result_ready = rr; in_result = res; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    if (!in_ready) check("issue_in_ready_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] req_data);
    push_exp(pc, rd, 1'b1, 1'b1, req_data, 1'b0);
    issue(pc, rd, 1'b1, 1'b1, 1'b0, size, uns, addr, 32'h0, 1'b0, 32'h0);
    $display("load pc=0x%0h addr=0x%0h size=%0d uns=%0d rdata=0x%0h req=0x%0h",
             pc, addr, size, uns, rdata, req_data);
    check("ld_req_valid", 64'(mem_req_valid), 64'd1);
    check("ld_req_write", 64'(mem_req_write), 64'd0);
    check("ld_req_addr", 64'(mem_req_addr), 64'(addr & 32'hFFFF_FFFC));
    check("ld_fwd_valid", 64'(fwd_valid), 64'd1);
    check("ld_fwd_data_ready", 64'(fwd_data_ready), 64'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("ld_resp_no_req", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    check("ld_out_valid", 64'(out_valid), 64'd1);
    check("ld_fwd_data", 64'(fwd_data), 64'(req_data));
    check("ld_fwd_data_ready_done", 64'(fwd_data_ready), 64'd1);
    step();
  endtask

  task automatic do_store(input logic [31:0] pc, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] req_wdata,
                          input logic [3:0] req_strobe, input int delay);
    push_exp(pc, 5'd0, 1'b0, 1'b1, 32'h0, 1'b0);
    issue(pc, 5'd0, 1'b0, 1'b0, 1'b1, size, 1'b0, addr, sdata, 1'b0, 32'h0);
    $display("store pc=0x%0h addr=0x%0h size=%0d wdata=0x%0h strobe=0x%0h delay=%0d",
             pc, addr, size, req_wdata, req_strobe, delay);
    for (int c = 0; c <= delay; c++) begin
      check("st_req_valid", 64'(mem_req_valid), 64'd1);
      check("st_req_write", 64'(mem_req_write), 64'd1);
      check("st_req_addr", 64'(mem_req_addr), 64'(addr & 32'hFFFF_FFFC));
      check("st_req_wdata", 64'(mem_req_wdata), 64'(req_wdata));
      check("st_req_strobe", 64'(mem_req_strobe), 64'(req_strobe));
      if (c == delay) mem_req_ready = 1'b1;
      step();
    end
    mem_req_ready = 1'b0;
    check("st_no_out_in_resp", 64'(out_valid), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("st_out_valid", 64'(out_valid), 64'd1);
    step();
  endtask

  // Monitor: every downstream handshake must match the oldest expected record.
  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("out pc=0x%0h rd=%0d rw=%0d dr=%0d data=0x%0h mis=%0d",
                 out_pc, out_rd, out_reg_write, out_data_ready, out_data, out_misaligned);
        check("out_pc", 64'(out_pc), 64'(e.pc));
        check("out_rd", 64'(out_rd), 64'(e.rd));
        check("out_reg_write", 64'(out_reg_write), 64'(e.reg_write));
        check("out_data_ready", 64'(out_data_ready), 64'(e.data_ready));
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_misaligned", 64'(out_misaligned), 64'(e.misaligned));
      end
    end
  end

  initial begin
    int k;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rd = '0; in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_size = 2'd0; in_unsigned = 1'b0; in_addr = '0; in_store_data = '0;
    in_result_ready = 1'b0; in_result = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_req_strobe", 64'(mem_req_strobe), 64'd0);
    check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    reset = 1'b1;
    step();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back ALU ops, one per cycle.
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h100 + 32'(4 * i); in_rd = 5'(i + 1); in_reg_write = 1'b1;
      in_mem_read = 1'b0; in_mem_write = 1'b0; in_result_ready = 1'b1;
      in_result = 32'h1234 + 32'(i); in_valid = 1'b1;
      push_exp(in_pc, in_rd, 1'b1, 1'b1, in_result, 1'b0);
      $display("alu pc=0x%0h result=0x%0h", in_pc, in_result);
      check("b2b_in_ready", 64'(in_ready), 64'd1);
      step();
      check("b2b_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();

    push_exp(32'h200, 5'd7, 1'b1, 1'b0, 32'h5555, 1'b0);
    issue(32'h200, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h5555);
    push_exp(32'h204, 5'd8, 1'b0, 1'b1, 32'h0, 1'b0);
    issue(32'h204, 5'd8, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD);
    step();

    // Output held stable under back-pressure.
    out_ready = 1'b0;
    push_exp(32'h300, 5'd3, 1'b1, 1'b1, 32'h77, 1'b0);
    issue(32'h300, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77);
    for (int c = 0; c < 2; c++) begin
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_data", 64'(out_data), 64'h77);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();

    do_load(32'h400, 5'd11, 2'd0, 1'b0, 32'h103, 32'h80FF_FFFF, 32'hFFFF_FF80);
    do_load(32'h404, 5'd12, 2'd0, 1'b1, 32'h103, 32'h80FF_FFFF, 32'h0000_0080);
    do_load(32'h408, 5'd13, 2'd1, 1'b0, 32'h102, 32'h80FF_FFFF, 32'hFFFF_80FF);
    do_load(32'h40C, 5'd14, 2'd1, 1'b1, 32'h102, 32'h80FF_FFFF, 32'h0000_80FF);
    do_load(32'h410, 5'd15, 2'd2, 1'b0, 32'h104, 32'h1234_5678, 32'h1234_5678);

    do_store(32'h500, 2'd1, 32'h2, 32'h0000_ABCD, 32'hABCD_ABCD, 4'b1100, 3);
    do_store(32'h504, 2'd0, 32'h1, 32'h0000_005A, 32'h5A5A_5A5A, 4'b0010, 0);
    do_store(32'h508, 2'd2, 32'h4, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 1);

    // Misaligned word load and half store: no bus traffic.
    push_exp(32'h600, 5'd9, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(32'h600, 5'd9, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b0, 32'h0);
    $display("misaligned lw addr=0x6");
    check("mis_ld_no_req", 64'(mem_req_valid), 64'd0);
    check("mis_ld_out_valid", 64'(out_valid), 64'd1);
    check("mis_ld_fwd_valid", 64'(fwd_valid), 64'd0);
    push_exp(32'h604, 5'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(32'h604, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h3, 32'h1111, 1'b0, 32'h0);
    $display("misaligned sh addr=0x3");
    check("mis_st_no_req", 64'(mem_req_valid), 64'd0);
    check("mis_st_out_valid", 64'(out_valid), 64'd1);
    step();

    // Flush while waiting for the response.
    issue(32'h700, 5'd10, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0);
    $display("flush during RESP pc=0x700");
    check("fl_req_valid", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    #1;
    check("fl_in_ready_low", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    check("fl_fwd_killed", 64'(fwd_valid), 64'd0);
    check("fl_no_req", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1111_1111;
    step();
    mem_resp_valid = 1'b0;
    check("fl_no_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    step();

    // Asynchronous reset in the middle of a request.
    issue(32'h800, 5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 1'b0, 32'h0);
    $display("reset during REQ pc=0x800");
    check("ar_req_valid", 64'(mem_req_valid), 64'd1);
    check("ar_fwd_valid", 64'(fwd_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req_valid_drop", 64'(mem_req_valid), 64'd0);
    check("ar_fwd_valid_drop", 64'(fwd_valid), 64'd0);
    check("ar_out_valid_drop", 64'(out_valid), 64'd0);
    step();
    reset = 1'b1;
    step();
    check("ar_in_ready", 64'(in_ready), 64'd1);

    push_exp(32'h900, 5'd6, 1'b1, 1'b1, 32'h1234, 1'b0);
    issue(32'h900, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1234);
    $display("alu after reset pc=0x900");

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      step();
      k++;
    end
    step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("out_count", 64'(n_out), 64'(n_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
